// File: rtl/spice_phase_sequencer_pkg.sv
// Shared state encoding for the half-phase sequencer.
package spice_phase_sequencer_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_LOAD   = 3'd1,
        SEQ_RELAX  = 3'd2,
        SEQ_SAMPLE = 3'd3,
        SEQ_TOGGLE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/spice_wrap_counter.sv
// Free-running wrap-around counter with synchronous clear (clear wins over enable).
module spice_wrap_counter #(
    parameter int W = 8
) (
    input  logic         eclk,
    input  logic         ereset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    // count up on en, wrap naturally at 2^W-1
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

endmodule

// File: rtl/spice_phase_sequencer.sv
// Half-phase sequencer for the switch-level netlist core:
// LOAD pins -> RELAX iterations -> SAMPLE latches -> TOGGLE phi0.
// Optional quiet-network early exit is built when SPICE_SEQ_SETTLE_EN is defined.
// All outputs are registered together with the state they belong to, so each
// strobe is high exactly while the FSM sits in its state.
import spice_phase_sequencer_pkg::*;

module spice_phase_sequencer #(
    parameter int ITERS  = 16,
    parameter int ITER_W = 8,
    parameter int CNT_W  = 32,
    parameter int SETTLE = 4
) (
    input  logic              eclk,
    input  logic              ereset,
    input  logic              run,
    input  logic              step_req,
    input  logic [ITER_W-1:0] iter_limit,
    input  logic              activity,
    output logic              pin_load,
    output logic              node_en,
    output logic              latch_g,
    output logic              phi0,
    output logic              busy,
    output logic              step_ack,
    output logic              settled,
    output logic [CNT_W-1:0]  cycle_count
);

    seq_state_t        state;
    logic              step_req_d;
    logic              step_mode;
    logic              early;
    logic [ITER_W-1:0] lim;
    logic [ITER_W-1:0] iter;
    logic              relax_last;
    logic              settle_hit;

    // iteration index: zeroed while loading, advanced once per RELAX cycle
    spice_wrap_counter #(.W(ITER_W)) u_iter (
        .eclk   (eclk),
        .ereset (ereset),
        .en     (state == SEQ_RELAX),
        .clr    (state == SEQ_LOAD),
        .count  (iter)
    );

    // full phi0 cycles: bump on the edge where phi0 falls (entering TOGGLE with phi0=1)
    spice_wrap_counter #(.W(CNT_W)) u_cycle (
        .eclk   (eclk),
        .ereset (ereset),
        .en     ((state == SEQ_SAMPLE) && phi0),
        .clr    (1'b0),
        .count  (cycle_count)
    );

    assign relax_last = (iter == lim - ITER_W'(1));

`ifdef SPICE_SEQ_SETTLE_EN
    logic [ITER_W-1:0] quiet;

    // consecutive quiet iterations; any activity restarts the run
    spice_wrap_counter #(.W(ITER_W)) u_quiet (
        .eclk   (eclk),
        .ereset (ereset),
        .en     ((state == SEQ_RELAX) && !activity),
        .clr    ((state == SEQ_LOAD) || ((state == SEQ_RELAX) && activity)),
        .count  (quiet)
    );

    // this cycle is the SETTLE-th quiet one in a row
    assign settle_hit = !activity
                     && (quiet == ITER_W'(SETTLE - 1))
                     && (iter >= ITER_W'(SETTLE - 1));
`else
    logic unused_activity;
    assign unused_activity = activity;
    assign settle_hit      = 1'b0;
`endif

    // sequencer FSM with outputs registered alongside the next state
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            state      <= SEQ_IDLE;
            step_req_d <= 1'b0;
            step_mode  <= 1'b0;
            early      <= 1'b0;
            lim        <= '0;
            pin_load   <= 1'b0;
            node_en    <= 1'b0;
            latch_g    <= 1'b0;
            phi0       <= 1'b0;
            busy       <= 1'b0;
            step_ack   <= 1'b0;
            settled    <= 1'b0;
        end else begin
            // edges seen while busy are consumed here and never start a phase
            step_req_d <= step_req;
            pin_load   <= 1'b0;
            node_en    <= 1'b0;
            latch_g    <= 1'b0;
            step_ack   <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (run) begin
                        state     <= SEQ_LOAD;
                        pin_load  <= 1'b1;
                        busy      <= 1'b1;
                        step_mode <= 1'b0;
                    end else if (step_req && !step_req_d) begin
                        state     <= SEQ_LOAD;
                        pin_load  <= 1'b1;
                        busy      <= 1'b1;
                        step_mode <= 1'b1;
                    end
                end
                SEQ_LOAD: begin
                    // limit is frozen here; later iter_limit changes wait for the next phase
                    lim     <= (iter_limit == '0) ? ITER_W'(ITERS) : iter_limit;
                    state   <= SEQ_RELAX;
                    node_en <= 1'b1;
                end
                SEQ_RELAX: begin
                    if (relax_last || settle_hit) begin
                        state   <= SEQ_SAMPLE;
                        latch_g <= 1'b1;
                        // hitting the limit on the same cycle is not an early exit
                        early   <= settle_hit && !relax_last;
                    end else begin
                        node_en <= 1'b1;
                    end
                end
                SEQ_SAMPLE: begin
                    state     <= SEQ_TOGGLE;
                    phi0      <= ~phi0;
                    step_ack  <= step_mode;
                    step_mode <= 1'b0;
                    settled   <= early;
                end
                SEQ_TOGGLE: begin
                    if (run) begin
                        state    <= SEQ_LOAD;
                        pin_load <= 1'b1;
                    end else begin
                        state <= SEQ_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
